// File: rtl/pll_rst_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pll_rst_seq_pkg
//  Description : Shared types and constants for the PLL reset sequencer:
//                sequencer state enum, default parameter values and the
//                cycle-counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pll_rst_seq_pkg;

    // Sequencer phases, in the order a healthy bring-up walks through them
    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    // Default parameter values (50 MHz reference clock)
    localparam int c_DEF_RST_PULSE_CYCLES    = 16;
    localparam int c_DEF_LOCK_TIMEOUT_CYCLES = 50000;
    localparam int c_DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int c_DEF_RETRY_CNT_W         = 8;

    // Width of the shared cycle counter: enough for the longest interval
    // plus one spare bit so the counter can never wrap.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Generic single-bit two-flop synchronizer with synchronous
//                active-high reset. Output is 0 while reset is applied.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops give the first stage a full cycle to settle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pll_rst_seq
//  Description : Reset sequencer downstream of the PLL. Pulses the PLL reset,
//                waits for lock (with timeout and retry), requires lock to be
//                continuously stable before releasing the system reset, and
//                restarts the whole sequence when lock is lost while running.
//                Optional feature macro: PLL_RST_SEQ_RETRY_CNT_EN adds the
//                saturating retry_cnt output and its RETRY_CNT_W parameter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_rst_seq
    import pll_rst_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = c_DEF_RST_PULSE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = c_DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = c_DEF_LOCK_STABLE_CYCLES
`ifdef PLL_RST_SEQ_RETRY_CNT_EN
   ,parameter int RETRY_CNT_W         = c_DEF_RETRY_CNT_W
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked_async,
    output logic pll_rst,
    output logic sys_rst,
    output logic ready,
    output logic timeout_pulse
`ifdef PLL_RST_SEQ_RETRY_CNT_EN
   ,output logic [RETRY_CNT_W-1:0] retry_cnt
`endif
);

    localparam int c_CNT_W = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                       LOCK_STABLE_CYCLES);

    // Each interval ends on the Nth edge spent in its state, i.e. when the
    // counter (cleared on entry) still shows N-1.
    localparam logic [c_CNT_W-1:0] c_RST_LAST    = c_CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_STABLE_LAST  = c_CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic                 w_timeout;
    logic                 w_locked_s;

    logic                 r_pll_rst;
    logic                 r_sys_rst;
    logic                 r_ready;
    logic                 r_timeout_pulse;

    // The raw lock input is only ever seen through this synchronizer
    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .i_d (pll_locked_async),
        .o_q (w_locked_s)
    );

    // Next-state, next-count and timeout decision
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_CNT_ONE;
        w_timeout   = 1'b0;
        case (r_state)
            PLL_RST: begin
                if (r_cnt == c_RST_LAST) w_state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout
                if (w_locked_s) begin
                    w_state_nxt = STABLE;
                end else if (r_cnt == c_TIMEOUT_LAST) begin
                    w_state_nxt = PLL_RST;
                    w_timeout   = 1'b1;
                end
            end
            STABLE: begin
                if (!w_locked_s)                w_state_nxt = WAIT_LOCK;
                else if (r_cnt == c_STABLE_LAST) w_state_nxt = RUN;
            end
            RUN: begin
                // Counter is idle while running so it can never wrap
                w_cnt_nxt = r_cnt;
                if (!w_locked_s) w_state_nxt = PLL_RST;
            end
            default: w_state_nxt = PLL_RST;
        endcase
        if (w_state_nxt != r_state) w_cnt_nxt = '0;
    end

    // State, counter and registered outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= PLL_RST;
            r_cnt           <= '0;
            r_pll_rst       <= 1'b1;
            r_sys_rst       <= 1'b1;
            r_ready         <= 1'b0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_pll_rst       <= (w_state_nxt == PLL_RST);
            r_sys_rst       <= (w_state_nxt != RUN);
            r_ready         <= (w_state_nxt == RUN);
            r_timeout_pulse <= w_timeout;
        end
    end

    assign pll_rst       = r_pll_rst;
    assign sys_rst       = r_sys_rst;
    assign ready         = r_ready;
    assign timeout_pulse = r_timeout_pulse;

`ifdef PLL_RST_SEQ_RETRY_CNT_EN
    logic [RETRY_CNT_W-1:0] r_retry_cnt;

    // Saturating count of lock-acquire timeouts; only rst clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retry_cnt <= '0;
        end else if (w_timeout && (r_retry_cnt != '1)) begin
            r_retry_cnt <= r_retry_cnt + RETRY_CNT_W'(1);
        end
    end

    assign retry_cnt = r_retry_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_rst_seq
//  Description : Scoreboard testbench for pll_rst_seq. A driver applies
//                directed and random lock/reset patterns and pushes the
//                outcome predicted by a timestamp-based reference model; a
//                monitor pops and compares every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_rst_seq;

    localparam int TP   = 4;
    localparam int TT   = 20;
    localparam int TL   = 8;
    localparam int RW   = 2;
    localparam int RMAX = (1 << RW) - 1;

    localparam int M_PULSE  = 0;
    localparam int M_WAIT   = 1;
    localparam int M_STABLE = 2;
    localparam int M_RUN    = 3;

    typedef struct packed {
        logic          pll_rst;
        logic          sys_rst;
        logic          ready;
        logic          tp;
        logic [RW-1:0] rc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          pll_locked_async;
    logic          pll_rst;
    logic          sys_rst;
    logic          ready;
    logic          timeout_pulse;
    logic [RW-1:0] rc_obs;

    int total = 0;
    int bad   = 0;

    exp_t exp_q[$];

    // Reference model state: phase and the edge index at which it began
    logic async_hist[$];
    int   phase     = M_PULSE;
    int   since     = 0;
    int   last_rst  = 0;
    int   retries   = 0;

`ifdef PLL_RST_SEQ_RETRY_CNT_EN
    logic [RW-1:0] retry_cnt;
    assign rc_obs = retry_cnt;
`else
    assign rc_obs = '0;
`endif

    pll_rst_seq #(
        .RST_PULSE_CYCLES    (TP),
        .LOCK_TIMEOUT_CYCLES (TT),
        .LOCK_STABLE_CYCLES  (TL)
`ifdef PLL_RST_SEQ_RETRY_CNT_EN
       ,.RETRY_CNT_W         (RW)
`endif
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pll_locked_async (pll_locked_async),
        .pll_rst          (pll_rst),
        .sys_rst          (sys_rst),
        .ready            (ready),
        .timeout_pulse    (timeout_pulse)
`ifdef PLL_RST_SEQ_RETRY_CNT_EN
       ,.retry_cnt        (retry_cnt)
`endif
    );

    always #10 clk = ~clk;

    // Predict the outputs after the edge just taken, given rst and the raw
    // lock level present at that edge. The lock level the sequencer acts on
    // is the raw level from two edges earlier, or 0 if a reset edge lies
    // within that window.
    task automatic model_edge(input logic r, input logic lk);
        exp_t e;
        logic ls;
        int   n;
        async_hist.push_back(lk);
        n    = async_hist.size() - 1;
        e.tp = 1'b0;
        if (r) begin
            phase    = M_PULSE;
            since    = n;
            last_rst = n;
            retries  = 0;
        end else begin
            ls = ((n - 2) > last_rst) ? async_hist[n-2] : 1'b0;
            case (phase)
                M_PULSE: begin
                    if (n - since == TP) begin phase = M_WAIT; since = n; end
                end
                M_WAIT: begin
                    if (ls) begin
                        phase = M_STABLE; since = n;
                    end else if (n - since == TT) begin
                        phase = M_PULSE; since = n; e.tp = 1'b1;
                        if (retries < RMAX) retries = retries + 1;
                    end
                end
                M_STABLE: begin
                    if (!ls) begin
                        phase = M_WAIT; since = n;
                    end else if (n - since == TL) begin
                        phase = M_RUN; since = n;
                    end
                end
                default: begin
                    if (!ls) begin phase = M_PULSE; since = n; end
                end
            endcase
        end
        e.pll_rst = (phase == M_PULSE);
        e.sys_rst = (phase != M_RUN);
        e.ready   = (phase == M_RUN);
`ifdef PLL_RST_SEQ_RETRY_CNT_EN
        e.rc      = RW'(retries);
`else
        e.rc      = '0;
`endif
        exp_q.push_back(e);
    endtask

    // One clock of stimulus: inputs change mid-cycle, prediction at the edge
    task automatic cycle(input logic r, input logic lk);
        rst              = r;
        pll_locked_async = lk;
        @(posedge clk);
        model_edge(r, lk);
        @(negedge clk);
    endtask

    // Monitor: compare DUT outputs shortly after each edge that has a prediction
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {pll_rst, sys_rst, ready, timeout_pulse, rc_obs};
                total = total + 1;
                if (got !== e) begin
                    bad = bad + 1;
                    $display("FAIL outputs t=%0t got pll_rst=%b sys_rst=%b ready=%b tp=%b rc=%0d want pll_rst=%b sys_rst=%b ready=%b tp=%b rc=%0d",
                             $time, got.pll_rst, got.sys_rst, got.ready, got.tp, got.rc,
                             e.pll_rst, e.sys_rst, e.ready, e.tp, e.rc);
                end
            end
        end
    end

    // Driver: directed scenarios followed by randomized lock/reset traffic
    initial begin
        int   run;
        logic lk;
        logic rr;
        rst              = 1'b1;
        pll_locked_async = 1'b0;
        @(negedge clk);
        repeat (3) cycle(1'b1, 1'b0);
        // No lock: first timeout and re-pulse
        repeat (30) cycle(1'b0, 1'b0);
        // Lock acquired and held into RUN
        repeat (20) cycle(1'b0, 1'b1);
        // Lock loss in RUN, then relock
        repeat (2)  cycle(1'b0, 1'b0);
        repeat (20) cycle(1'b0, 1'b1);
        // Lock loss, then a 2-cycle dropout during STABLE
        repeat (10) cycle(1'b0, 1'b0);
        repeat (5)  cycle(1'b0, 1'b1);
        repeat (2)  cycle(1'b0, 1'b0);
        repeat (15) cycle(1'b0, 1'b1);
        // Repeated timeouts drive the retry count into saturation
        repeat (130) cycle(1'b0, 1'b0);
        // Reach RUN, then reset while running
        repeat (20) cycle(1'b0, 1'b1);
        repeat (2)  cycle(1'b1, 1'b1);
        repeat (20) cycle(1'b0, 1'b1);
        // Random runs of lock/unlock with occasional reset pulses
        repeat (60) begin
            run = $urandom_range(1, 40);
            lk  = logic'($urandom_range(0, 1));
            rr  = ($urandom_range(0, 99) < 4);
            for (int i = 0; i < run; i++) cycle(rr && (i == 0), lk);
        end
        repeat (3) @(negedge clk);
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
